// File: rtl/data_sram_if.sv
// CPU data SRAM-like bus: request channel (req/wr/wen/addr/wdata -> addr_ok)
// and response channel (data_ok/rdata). The responder sits on the slave side.
interface data_sram_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// data_sram_responder: word-addressed data memory behind the SRAM-like bus.
// Requests are accepted in order, each answered LATENCY cycles after its
// accept edge, with at most OUTSTANDING requests in flight.
// Optional: define DSRAM_RESP_STALL_EN to add LFSR-driven addr_ok stalls.
module data_sram_responder #(
  parameter int ADDR_W      = 10,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic       clk,
  input  logic       reset,
  data_sram_if.slave bus
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int DEPTH = 1 << ADDR_W;

  // Memory contents survive reset on purpose.
  logic [31:0] mem [DEPTH];

  // Pending-response queue (circular, in accept order).
  logic        ent_ld_q   [OUTSTANDING];
  logic        ent_ld_d   [OUTSTANDING];
  logic [31:0] ent_data_q [OUTSTANDING];
  logic [31:0] ent_data_d [OUTSTANDING];
  logic [3:0]  ent_cnt_q  [OUTSTANDING];
  logic [3:0]  ent_cnt_d  [OUTSTANDING];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             data_ok_q, data_ok_d;
  logic [31:0]      rdata_q, rdata_d;

  logic              addr_ok;
  logic              accept;
  logic              pop;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       mem_rd;
  logic              unused_addr_bits;

  assign widx             = bus.data_sram_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0]};
  assign mem_rd           = mem[widx];

`ifdef DSRAM_RESP_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Stall generator: x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR register, reseeded on reset.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end

  assign addr_ok = !reset && (pend_q < CNT_W'(OUTSTANDING)) && !lfsr_q[0];
`else
  assign addr_ok = !reset && (pend_q < CNT_W'(OUTSTANDING));
`endif

  assign accept = bus.data_sram_req && addr_ok;

  assign bus.data_sram_addr_ok = addr_ok;
  assign bus.data_sram_data_ok = data_ok_q;
  assign bus.data_sram_rdata   = rdata_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Store path: enabled bytes land at the accept edge.
  always_ff @(posedge clk) begin
    if (accept && bus.data_sram_wr) begin
      for (int b = 0; b < 4; b++)
        if (bus.data_sram_wen[b]) mem[widx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
    end
  end

  // Queue bookkeeping. Each entry counts down toward its pop edge; the head
  // is popped when its count is at most 1, i.e. LATENCY-1 edges after accept.
  // With LATENCY==1 a request is answered from its own accept edge directly.
  always_comb begin
    ent_ld_d   = ent_ld_q;
    ent_data_d = ent_data_q;
    ent_cnt_d  = ent_cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    pend_d     = pend_q;
    data_ok_d  = 1'b0;
    rdata_d    = rdata_q;
    pop        = 1'b0;

    for (int i = 0; i < OUTSTANDING; i++)
      if (ent_cnt_q[i] != 4'd0) ent_cnt_d[i] = ent_cnt_q[i] - 4'd1;

    if (LATENCY == 1) begin
      if (accept) begin
        data_ok_d = 1'b1;
        rdata_d   = bus.data_sram_wr ? 32'h0 : mem_rd;
      end
    end else begin
      pop = (pend_q != '0) && (ent_cnt_q[head_q] <= 4'd1);
      if (pop) begin
        data_ok_d = 1'b1;
        rdata_d   = ent_ld_q[head_q] ? ent_data_q[head_q] : 32'h0;
        head_d    = ptr_inc(head_q);
      end
      if (accept) begin
        ent_ld_d[tail_q]   = !bus.data_sram_wr;
        ent_data_d[tail_q] = bus.data_sram_wr ? 32'h0 : mem_rd;
        ent_cnt_d[tail_q]  = 4'(LATENCY - 1);
        tail_d             = ptr_inc(tail_q);
      end
      pend_d = pend_q + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  // Queue payload; validity is tracked by pend/head/tail, so no reset needed.
  always_ff @(posedge clk) begin
    ent_ld_q   <= ent_ld_d;
    ent_data_q <= ent_data_d;
    ent_cnt_q  <= ent_cnt_d;
  end

  // Control and response registers; reset drops every pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      pend_q    <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      pend_q    <= pend_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule
